// File: rtl/fifo_fwft_param_if.sv
// Handshake bundle between a producer/consumer pair and fifo_fwft_param.
// master drives requests, slave is the FIFO returning head data and status.
interface fifo_fwft_param_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_SIZE  = 4
);
  logic                  flush;
  logic                  write_en;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  read_en;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  empty;
  logic                  full;
  logic                  almost_empty;
  logic                  almost_full;
  logic [ADDR_SIZE:0]    count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush,
    output write_en,
    output write_data,
    output read_en,
    input  read_data,
    input  empty,
    input  full,
    input  almost_empty,
    input  almost_full,
    input  count,
    input  overflow,
    input  underflow
  );

  modport slave (
    input  flush,
    input  write_en,
    input  write_data,
    input  read_en,
    output read_data,
    output empty,
    output full,
    output almost_empty,
    output almost_full,
    output count,
    output overflow,
    output underflow
  );
endinterface

// File: rtl/fifo_fwft_param.sv
// Parametrised first-word-fall-through FIFO with occupancy count,
// programmable almost flags, synchronous flush and sticky error flags.
module fifo_fwft_param #(
  parameter int DATA_WIDTH         = 8,
  parameter int ADDR_SIZE          = 4,
  parameter int ALMOST_FULL_LEVEL  = 14,
  parameter int ALMOST_EMPTY_LEVEL = 2
) (
  input  logic             clk,
  input  logic             reset,
  fifo_fwft_param_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_SIZE;
  localparam int PW    = ADDR_SIZE + 1;

  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
  localparam logic [PW-1:0] AF_C    = PW'(ALMOST_FULL_LEVEL);
  localparam logic [PW-1:0] AE_C    = PW'(ALMOST_EMPTY_LEVEL);

  if (ADDR_SIZE < 1) begin : g_bad_addr
    $error("fifo_fwft_param: ADDR_SIZE must be >= 1");
  end
  if (ALMOST_FULL_LEVEL < 1 || ALMOST_FULL_LEVEL > DEPTH) begin : g_bad_af
    $error("fifo_fwft_param: ALMOST_FULL_LEVEL out of 1..DEPTH");
  end
  if (ALMOST_EMPTY_LEVEL < 0 ||
      ALMOST_EMPTY_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("fifo_fwft_param: ALMOST_EMPTY_LEVEL out of 0..DEPTH-1");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [PW-1:0]        cnt;
  logic [ADDR_SIZE-1:0] wr_idx;
  logic [ADDR_SIZE-1:0] rd_idx;
  logic                 ovf;
  logic                 unf;
  logic                 is_empty;
  logic                 is_full;
  logic                 rd_acc;
  logic                 wr_acc;

  assign wr_idx = wr_ptr[ADDR_SIZE-1:0];
  assign rd_idx = rd_ptr[ADDR_SIZE-1:0];

  // Status and acceptance; flush blocks both sides for the cycle.
  always_comb begin
    is_empty = (cnt == '0);
    is_full  = (cnt == DEPTH_C);
    rd_acc   = bus.read_en && !is_empty && !bus.flush;
    wr_acc   = bus.write_en && (!is_full || rd_acc) && !bus.flush;
  end

  assign bus.empty        = is_empty;
  assign bus.full         = is_full;
  assign bus.almost_empty = (cnt <= AE_C);
  assign bus.almost_full  = (cnt >= AF_C);
  assign bus.count        = cnt;
  assign bus.overflow     = ovf;
  assign bus.underflow    = unf;
  assign bus.read_data    = is_empty ? '0 : mem[rd_idx];

  // Storage array; contents survive reset and flush.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_idx] <= bus.write_data;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case (1'b1)
        wr_acc && !rd_acc: cnt <= cnt + 1'b1;
        rd_acc && !wr_acc: cnt <= cnt - 1'b1;
        default:           cnt <= cnt;
      endcase
    end
  end

  // Sticky error flags, cleared only by reset or flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else if (bus.flush) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (bus.write_en && !wr_acc) begin
        ovf <= 1'b1;
      end
      if (bus.read_en && !rd_acc) begin
        unf <= 1'b1;
      end
    end
  end

  // Occupancy must always equal the pointer distance.
  a_cnt_ptr: assert property (
    @(posedge clk) disable iff (!reset)
    cnt == PW'(wr_ptr - rd_ptr)
  );

  // Occupancy never exceeds the array size.
  a_cnt_max: assert property (
    @(posedge clk) disable iff (!reset)
    cnt <= DEPTH_C
  );

endmodule

// File: tb/tb_fifo_fwft_param.sv
// Scoreboard bench for fifo_fwft_param: an 8x16 and a 16x8 instance
// run side by side against a queue model of the FIFO.
module tb_fifo_fwft_param;

  logic clk;
  logic reset;

  int n_chk;
  int n_pass;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  bit ov0, un0, ov1, un1;

  fifo_fwft_param_if #(.DATA_WIDTH(8), .ADDR_SIZE(4)) b1();
  fifo_fwft_param_if #(.DATA_WIDTH(16), .ADDR_SIZE(3)) b2();

  fifo_fwft_param #(
    .DATA_WIDTH(8),
    .ADDR_SIZE(4),
    .ALMOST_FULL_LEVEL(14),
    .ALMOST_EMPTY_LEVEL(2)
  ) u_dut8 (
    .clk(clk),
    .reset(reset),
    .bus(b1)
  );

  fifo_fwft_param #(
    .DATA_WIDTH(16),
    .ADDR_SIZE(3),
    .ALMOST_FULL_LEVEL(6),
    .ALMOST_EMPTY_LEVEL(1)
  ) u_dut16 (
    .clk(clk),
    .reset(reset),
    .bus(b2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic check_state(
    input string p,
    input int depth, input int afl, input int ael,
    input int n, input logic [31:0] head,
    input bit ovf, input bit unf,
    input logic [31:0] g_cnt, input logic [31:0] g_rd,
    input logic g_e, input logic g_f,
    input logic g_ae, input logic g_af,
    input logic g_ov, input logic g_un);
    chk({p, " count"}, g_cnt, 32'(n));
    chk({p, " rdata"}, g_rd, head);
    chk({p, " empty"}, 32'(g_e), 32'(n == 0));
    chk({p, " full"}, 32'(g_f), 32'(n == depth));
    chk({p, " aempty"}, 32'(g_ae), 32'(n <= ael));
    chk({p, " afull"}, 32'(g_af), 32'(n >= afl));
    chk({p, " ovf"}, 32'(g_ov), 32'(ovf));
    chk({p, " unf"}, 32'(g_un), 32'(unf));
  endtask

  task automatic check_all();
    check_state("d8", 16, 14, 2, q0.size(),
      (q0.size() != 0) ? q0[0] : 32'h0, ov0, un0,
      32'(b1.count), 32'(b1.read_data),
      b1.empty, b1.full, b1.almost_empty, b1.almost_full,
      b1.overflow, b1.underflow);
    check_state("d16", 8, 6, 1, q1.size(),
      (q1.size() != 0) ? q1[0] : 32'h0, ov1, un1,
      32'(b2.count), 32'(b2.read_data),
      b2.empty, b2.full, b2.almost_empty, b2.almost_full,
      b2.overflow, b2.underflow);
  endtask

  // Apply the current inputs for one edge, then compare.
  task automatic tick();
    bit ra;
    bit wa;
    ra = b1.read_en && q0.size() != 0 && !b1.flush;
    wa = b1.write_en && (q0.size() != 16 || ra) && !b1.flush;
    if (b1.flush) begin
      q0.delete();
      ov0 = 1'b0;
      un0 = 1'b0;
    end else begin
      if (ra) chk("d8 pop", 32'(b1.read_data), q0.pop_front());
      if (b1.read_en && !ra) un0 = 1'b1;
      if (b1.write_en && !wa) ov0 = 1'b1;
      if (wa) q0.push_back(32'(b1.write_data));
    end
    ra = b2.read_en && q1.size() != 0 && !b2.flush;
    wa = b2.write_en && (q1.size() != 8 || ra) && !b2.flush;
    if (b2.flush) begin
      q1.delete();
      ov1 = 1'b0;
      un1 = 1'b0;
    end else begin
      if (ra) chk("d16 pop", 32'(b2.read_data), q1.pop_front());
      if (b2.read_en && !ra) un1 = 1'b1;
      if (b2.write_en && !wa) ov1 = 1'b1;
      if (wa) q1.push_back(32'(b2.write_data));
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    b1.flush = 0; b1.write_en = 0; b1.read_en = 0; b1.write_data = '0;
    b2.flush = 0; b2.write_en = 0; b2.read_en = 0; b2.write_data = '0;
  endtask

  // Short reset pulse while clk is high; state must clear at once.
  task automatic pulse_reset();
    reset = 1'b0;
    #1;
    q0.delete(); q1.delete();
    ov0 = 0; un0 = 0; ov1 = 0; un1 = 0;
    chk("rst d8 count", 32'(b1.count), 32'd0);
    chk("rst d8 empty", 32'(b1.empty), 32'd1);
    chk("rst d16 count", 32'(b2.count), 32'd0);
    chk("rst d16 empty", 32'(b2.empty), 32'd1);
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    int v1;
    bit w0;
    bit w1;
    n_chk = 0;
    n_pass = 0;
    idle();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset = 1'b1;

    // Fill with 0..15.
    for (int i = 0; i < 16; i++) begin
      b1.write_en = 1; b1.write_data = 8'(i);
      tick();
    end
    // Overflow attempt, then drain.
    b1.write_data = 8'hAA;
    tick();
    b1.write_en = 0; b1.read_en = 1;
    for (int i = 0; i < 16; i++) tick();
    // Underflow, then flush with both requests held.
    tick();
    b1.flush = 1; b1.write_en = 1; b1.read_en = 1;
    tick();
    idle();
    // Refill, then 32 cycles of write+read at full.
    for (int i = 0; i < 16; i++) begin
      b1.write_en = 1; b1.write_data = 8'(i);
      tick();
    end
    b1.read_en = 1;
    for (int i = 16; i < 48; i++) begin
      b1.write_data = 8'(i);
      tick();
    end
    idle();
    // Simultaneous write+read on empty.
    b1.flush = 1;
    tick();
    b1.flush = 0; b1.write_en = 1; b1.read_en = 1;
    b1.write_data = 8'h55;
    tick();
    b1.write_en = 0;
    tick();
    b1.read_en = 0; b1.flush = 1;
    tick();
    idle();

    // Long interleaved run on both instances.
    v0 = 0;
    v1 = 0;
    for (int i = 0; i < 512; i++) begin
      if (i == 256) pulse_reset();
      b1.write_en = q0.size() != 16;
      b1.write_data = 8'(v0);
      b1.read_en = (i % 20 == 0) && q0.size() != 0;
      b2.write_en = q1.size() != 8;
      b2.write_data = 16'(v1);
      b2.read_en = (i % 20 == 0) && q1.size() != 0;
      w0 = b1.write_en;
      w1 = b2.write_en;
      tick();
      if (w0) v0++;
      if (w1) v1++;
    end
    idle();
    b1.read_en = 1;
    b2.read_en = 1;
    for (int i = 0; i < 17; i++) tick();
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
